// File: rtl/gate_test_sequencer.sv
// On-chip self-test sequencer for a 2-input gate: applies vectors 00..11, samples the gate
// output after a settle period and reports pass, mismatch count and per-vector failure mask.
module gate_test_sequencer #(
  parameter logic [3:0]  TruthTable   = 4'b0110,
  parameter int unsigned SettleCycles = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic       gate_c_i,
  output logic       gate_a_o,
  output logic       gate_b_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       pass_o,
  output logic [2:0] err_count_o,
  output logic [3:0] err_mask_o
);

  localparam int unsigned CntW = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
  localparam logic [CntW-1:0] CntReload = CntW'(SettleCycles - 1);

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

  state_e          state_q;
  logic [1:0]      idx_q;
  logic [CntW-1:0] cnt_q;
  logic            gate_a_q, gate_b_q;
  logic            busy_q, done_q, pass_q;
  logic [2:0]      err_count_q;
  logic [3:0]      err_mask_q;
  logic            mismatch;
  logic            abort_run;

  // Case-inequality so an X/Z gate output is flagged as a mismatch in simulation.
  assign mismatch  = (gate_c_i !== TruthTable[idx_q]);
  assign abort_run = abort_i && ((state_q == StSettle) || (state_q == StSample));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      idx_q       <= 2'd0;
      cnt_q       <= '0;
      gate_a_q    <= 1'b0;
      gate_b_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= 3'd0;
      err_mask_q  <= 4'd0;
    end else if (abort_run) begin
      state_q     <= StIdle;
      idx_q       <= 2'd0;
      cnt_q       <= '0;
      gate_a_q    <= 1'b0;
      gate_b_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= 3'd0;
      err_mask_q  <= 4'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start_i && !abort_i) begin
            idx_q       <= 2'd0;
            gate_a_q    <= 1'b0;
            gate_b_q    <= 1'b0;
            cnt_q       <= CntReload;
            err_count_q <= 3'd0;
            err_mask_q  <= 4'd0;
            pass_q      <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= StSettle;
          end
        end
        StSettle: begin
          if (cnt_q == '0) begin
            state_q <= StSample;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StSample: begin
          if (mismatch) begin
            err_mask_q[idx_q] <= 1'b1;
            err_count_q       <= err_count_q + 3'd1;
          end
          if (idx_q == 2'd3) begin
            busy_q   <= 1'b0;
            gate_a_q <= 1'b0;
            gate_b_q <= 1'b0;
            state_q  <= StDone;
          end else begin
            idx_q                <= idx_q + 2'd1;
            {gate_a_q, gate_b_q} <= idx_q + 2'd1;
            cnt_q                <= CntReload;
            state_q              <= StSettle;
          end
        end
        StDone: begin
          // err_mask_q already holds the vector-3 result here.
          done_q  <= 1'b1;
          pass_q  <= (err_mask_q == 4'd0);
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign gate_a_o    = gate_a_q;
  assign gate_b_o    = gate_b_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign err_count_o = err_count_q;
  assign err_mask_o  = err_mask_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Directed bench for gate_test_sequencer: a behavioural gate model with selectable faults
// feeds a SettleCycles=1 instance; a second SettleCycles=3 instance covers reset mid-run.
module tb_gate_test_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0;
  logic start = 1'b0, abort = 1'b0;
  logic start3 = 1'b0, abort3 = 1'b0;
  logic [1:0] mode = 2'd0;

  logic gc, ga, gb, busy, done, pass;
  logic [2:0] ecnt;
  logic [3:0] emask;
  logic gc3, ga3, gb3, busy3, done3, pass3;
  logic [2:0] ecnt3;
  logic [3:0] emask3;

  int errors = 0;
  int checks = 0;

  // mode 0: good XOR, 1: stuck-at-0, 2: X on vector 10, 3: inverted XOR
  always_comb begin
    gc = ga ^ gb;
    case (mode)
      2'd1: gc = 1'b0;
      2'd2: gc = (ga && !gb) ? 1'bx : (ga ^ gb);
      2'd3: gc = ~(ga ^ gb);
      default: gc = ga ^ gb;
    endcase
  end
  assign gc3 = ga3 ^ gb3;

  gate_test_sequencer #(.TruthTable(4'b0110), .SettleCycles(1)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .gate_c_i(gc),
    .gate_a_o(ga), .gate_b_o(gb), .busy_o(busy), .done_o(done), .pass_o(pass),
    .err_count_o(ecnt), .err_mask_o(emask)
  );

  gate_test_sequencer #(.TruthTable(4'b0110), .SettleCycles(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .start_i(start3), .abort_i(abort3), .gate_c_i(gc3),
    .gate_a_o(ga3), .gate_b_o(gb3), .busy_o(busy3), .done_o(done3), .pass_o(pass3),
    .err_count_o(ecnt3), .err_mask_o(emask3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({busy, done, pass, ga, gb, ecnt, emask} !== 12'd0) begin
      errors++;
      $display("FAIL reset_s1: got %b want 0", {busy, done, pass, ga, gb, ecnt, emask});
    end
    checks++;
    if ({busy3, done3, pass3, ga3, gb3, ecnt3, emask3} !== 12'd0) begin
      errors++;
      $display("FAIL reset_s3: got %b want 0", {busy3, done3, pass3, ga3, gb3, ecnt3, emask3});
    end
  endtask

  task automatic test_good_xor();
    logic [1:0] v;
    mode  = 2'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      v = 2'(k / 2);
      checks++;
      if ({busy, done, ga, gb} !== {2'b10, v}) begin
        errors++;
        $display("FAIL good_vec k=%0d: got %b want %b", k, {busy, done, ga, gb}, {2'b10, v});
      end
    end
    tick();
    checks++;
    if ({busy, done, ga, gb} !== 4'b0000) begin
      errors++;
      $display("FAIL good_edge8: got %b want 0000", {busy, done, ga, gb});
    end
    tick();
    checks++;
    if ({done, pass, ecnt, emask} !== {2'b11, 3'd0, 4'd0}) begin
      errors++;
      $display("FAIL good_done: got %b want 110000000", {done, pass, ecnt, emask});
    end
    tick();
    checks++;
    if ({done, pass} !== 2'b01) begin
      errors++;
      $display("FAIL good_hold: got %b want 01", {done, pass});
    end
  endtask

  task automatic test_stuck0();
    int n = 0;
    mode  = 2'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (!done && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (n != 9) begin
      errors++;
      $display("FAIL stuck0_latency: got %0d want 9", n);
    end
    checks++;
    if ({pass, ecnt, emask} !== {1'b0, 3'd2, 4'b0110}) begin
      errors++;
      $display("FAIL stuck0_result: got %b want 00100110", {pass, ecnt, emask});
    end
  endtask

  task automatic test_x_output();
    int n = 0;
    mode  = 2'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (!done && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (n != 9) begin
      errors++;
      $display("FAIL xout_latency: got %0d want 9", n);
    end
    checks++;
    if ({pass, ecnt, emask} !== {1'b0, 3'd1, 4'b0100}) begin
      errors++;
      $display("FAIL xout_result: got %b want 00010100", {pass, ecnt, emask});
    end
  endtask

  task automatic test_abort();
    int ndone = 0;
    mode  = 2'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    checks++;
    if ({busy, ga, gb, ecnt, emask} !== {3'b101, 3'd1, 4'b0001}) begin
      errors++;
      $display("FAIL abort_pre: got %b want 1010010001", {busy, ga, gb, ecnt, emask});
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({busy, ga, gb, pass, ecnt, emask} !== 11'd0) begin
      errors++;
      $display("FAIL abort_post: got %b want 0", {busy, ga, gb, pass, ecnt, emask});
    end
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done || busy) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d active cycles want 0", ndone);
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int extra = 0;
    mode  = 2'd0;
    start = 1'b1;
    while (!done && n < 30) begin
      tick();
      n++;
    end
    start = 1'b0;
    checks++;
    if (n != 10 || pass !== 1'b1) begin
      errors++;
      $display("FAIL held_start_run: got n=%0d pass=%b want n=10 pass=1", n, pass);
    end
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done || busy) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL held_start_single: got %0d active cycles want 0", extra);
    end
    start = 1'b1;
    abort = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (done || busy) extra++;
    end
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (extra != 0 || pass !== 1'b1) begin
      errors++;
      $display("FAIL start_abort_idle: got active=%0d pass=%b want 0 1", extra, pass);
    end
  endtask

  task automatic test_reset_midrun();
    int n = 0;
    int nbusy = 1;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    checks++;
    if ({busy3, ga3, gb3} !== 3'b101) begin
      errors++;
      $display("FAIL s3_midrun: got %b want 101", {busy3, ga3, gb3});
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({busy3, done3, pass3, ga3, gb3, ecnt3, emask3} !== 12'd0) begin
      errors++;
      $display("FAIL s3_reset: got %b want 0", {busy3, done3, pass3, ga3, gb3, ecnt3, emask3});
    end
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    while (!done3 && n < 40) begin
      tick();
      n++;
      if (busy3) nbusy++;
    end
    checks++;
    if (n != 17) begin
      errors++;
      $display("FAIL s3_latency: got %0d want 17", n);
    end
    checks++;
    if (nbusy != 16) begin
      errors++;
      $display("FAIL s3_busy_len: got %0d want 16", nbusy);
    end
    checks++;
    if ({pass3, ecnt3, emask3} !== {1'b1, 3'd0, 4'd0}) begin
      errors++;
      $display("FAIL s3_result: got %b want 10000000", {pass3, ecnt3, emask3});
    end
  endtask

  initial begin
    test_reset();
    test_good_xor();
    test_stuck0();
    test_x_output();
    test_abort();
    test_back_to_back();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
